// File: rtl/fp_csr_flags_if.sv
// CSR access port and FP retirement/rounding-mode signals of the fp_csr_flags block.
// The master drives requests and retirements; the slave (fp_csr_flags) returns read data and rm.
interface fp_csr_flags_if #(
   parameter int unsigned XLEN = 32
);
   logic            csr_valid;
   logic [11:0]     csr_addr;
   logic [1:0]      csr_op;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_hit;

   logic            fp_valid;
   logic [4:0]      fp_flags;
   logic [2:0]      instr_rm;
   logic [2:0]      rm_out;
   logic            rm_illegal;

   modport master (
      output csr_valid, csr_addr, csr_op, csr_wdata,
      output fp_valid, fp_flags, instr_rm,
      input  csr_rdata, csr_hit, rm_out, rm_illegal
   );

   modport slave (
      input  csr_valid, csr_addr, csr_op, csr_wdata,
      input  fp_valid, fp_flags, instr_rm,
      output csr_rdata, csr_hit, rm_out, rm_illegal
   );
endinterface

// File: rtl/fp_csr_flags.sv
// Floating-point CSR block: owns frm/fflags, accrues sticky FP exception flags,
// serves Zicsr accesses to fflags/frm/fcsr and resolves the dynamic rounding mode.
module fp_csr_flags #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   fp_csr_flags_if.slave   bus,
   output logic [2:0]      frm_out,
   output logic [4:0]      fflags_out,
   output logic            fs_dirty
);

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_RW  = 2'b01,
      OP_RS  = 2'b10,
      OP_RC  = 2'b11
   } csr_op_e;

   typedef enum logic [11:0] {
      ADDR_FFLAGS = 12'h001,
      ADDR_FRM    = 12'h002,
      ADDR_FCSR   = 12'h003
   } csr_addr_e;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100,
      RM_RS5 = 3'b101,
      RM_RS6 = 3'b110,
      RM_DYN = 3'b111
   } rm_e;

   logic [2:0] frm_q;
   logic [4:0] fflags_q;
   logic       fs_dirty_q;

   logic [2:0] frm_nxt;
   logic [4:0] fflags_nxt;
   logic       fs_dirty_nxt;

   csr_op_e    op;
   logic [4:0] f_byp;
   logic [7:0] old8;
   logic [7:0] wd8;
   logic [7:0] w8;
   logic       hit;
   logic       csr_write;
   rm_e        rm_eff;

   logic       unused_wdata_hi;

   assign op    = csr_op_e'(bus.csr_op);
   assign wd8   = bus.csr_wdata[7:0];
   assign f_byp = fflags_q | (bus.fp_valid ? bus.fp_flags : 5'b0);

   assign unused_wdata_hi = ^bus.csr_wdata[XLEN-1:8];

   // Field view of the addressed CSR, including the same-cycle flag bypass;
   // it doubles as the "old" value for set/clear writes.
   always_comb begin
      hit  = 1'b0;
      old8 = '0;
      case (bus.csr_addr)
         ADDR_FFLAGS: begin
            hit  = 1'b1;
            old8 = {3'b000, f_byp};
         end
         ADDR_FRM: begin
            hit  = 1'b1;
            old8 = {5'b00000, frm_q};
         end
         ADDR_FCSR: begin
            hit  = 1'b1;
            old8 = {frm_q, f_byp};
         end
         default: begin
            hit  = 1'b0;
            old8 = '0;
         end
      endcase
   end

   assign bus.csr_hit   = hit;
   assign bus.csr_rdata = XLEN'(old8);

   always_comb begin
      w8 = old8;
      case (op)
         OP_RW:   w8 = wd8;
         OP_RS:   w8 = old8 | wd8;
         OP_RC:   w8 = old8 & ~wd8;
         default: w8 = old8;
      endcase
   end

   assign csr_write = bus.csr_valid && hit && (op != OP_NOP);

   // CSR-written field first, then retiring flags ORed on top, so a clear
   // never suppresses a flag raised in the same cycle.
   always_comb begin
      frm_nxt    = frm_q;
      fflags_nxt = fflags_q;
      if (csr_write) begin
         case (bus.csr_addr)
            ADDR_FFLAGS: fflags_nxt = w8[4:0];
            ADDR_FRM:    frm_nxt    = w8[2:0];
            ADDR_FCSR: begin
               frm_nxt    = w8[7:5];
               fflags_nxt = w8[4:0];
            end
            default: begin
               frm_nxt    = frm_q;
               fflags_nxt = fflags_q;
            end
         endcase
      end
      if (bus.fp_valid) begin
         fflags_nxt = fflags_nxt | bus.fp_flags;
      end
   end

   assign fs_dirty_nxt = csr_write || (bus.fp_valid && (bus.fp_flags != 5'b0));

   always_ff @(posedge clk) begin
      if (reset) begin
         frm_q      <= '0;
         fflags_q   <= '0;
         fs_dirty_q <= 1'b0;
      end else begin
         frm_q      <= frm_nxt;
         fflags_q   <= fflags_nxt;
         fs_dirty_q <= fs_dirty_nxt;
      end
   end

   always_comb begin
      rm_eff = rm_e'(bus.instr_rm);
      if (rm_e'(bus.instr_rm) == RM_DYN) begin
         rm_eff = rm_e'(frm_q);
      end
   end

   assign bus.rm_out     = rm_eff;
   assign bus.rm_illegal = (rm_eff == RM_RS5) || (rm_eff == RM_RS6) || (rm_eff == RM_DYN);

   assign frm_out    = frm_q;
   assign fflags_out = fflags_q;
   assign fs_dirty   = fs_dirty_q;

endmodule

// File: tb/tb_fp_csr_flags.sv
// Self-checking bench for fp_csr_flags: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic reference model.
module tb_fp_csr_flags;

   logic       clk;
   logic       reset;
   logic [2:0] frm_out;
   logic [4:0] fflags_out;
   logic       fs_dirty;

   int n_cmp;
   int n_bad;

   // reference model state
   int unsigned m_frm;
   int unsigned m_ff;
   int unsigned m_dirty;
   bit          m_valid;

   fp_csr_flags_if #(.XLEN(32)) bus ();

   fp_csr_flags #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .frm_out    (frm_out),
      .fflags_out (fflags_out),
      .fs_dirty   (fs_dirty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned m_read(input int unsigned addr);
      int unsigned f;
      f = m_ff | (bus.fp_valid ? 32'(bus.fp_flags) : 0);
      case (addr)
         1: return f;
         2: return m_frm;
         3: return m_frm * 32 + f;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_hit(input int unsigned addr);
      return (addr >= 1) && (addr <= 3);
   endfunction

   task automatic model_check();
      int unsigned addr;
      int unsigned eff;
      if (!m_valid) return;
      addr = 32'(bus.csr_addr);
      eff  = (bus.instr_rm == 3'd7) ? m_frm : 32'(bus.instr_rm);
      check("csr_rdata",  bus.csr_rdata,          m_read(addr));
      check("csr_hit",    32'(bus.csr_hit),       32'(m_hit(addr)));
      check("rm_out",     32'(bus.rm_out),        eff);
      check("rm_illegal", 32'(bus.rm_illegal),    (eff >= 5) ? 1 : 0);
      check("frm_out",    32'(frm_out),           m_frm);
      check("fflags_out", 32'(fflags_out),        m_ff);
      check("fs_dirty",   32'(fs_dirty),          m_dirty);
   endtask

   task automatic model_update();
      int unsigned addr, old, w, wd, op;
      bit wr;
      if (reset) begin
         m_frm = 0; m_ff = 0; m_dirty = 0; m_valid = 1;
         return;
      end
      addr = 32'(bus.csr_addr);
      op   = 32'(bus.csr_op);
      wd   = bus.csr_wdata;
      old  = m_read(addr);
      wr   = bus.csr_valid && m_hit(addr) && (op != 0);
      w    = (op == 1) ? wd : (op == 2) ? (old | wd) : (old & ~wd);
      if (wr) begin
         if (addr == 1) m_ff = w % 32;
         if (addr == 2) m_frm = w % 8;
         if (addr == 3) begin
            m_frm = (w / 32) % 8;
            m_ff  = w % 32;
         end
      end
      if (bus.fp_valid) m_ff = m_ff | 32'(bus.fp_flags);
      m_dirty = (wr || (bus.fp_valid && bus.fp_flags != 0)) ? 1 : 0;
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit cv, input int unsigned addr, input int unsigned op,
                        input int unsigned wd, input bit fv, input int unsigned ff,
                        input int unsigned rm);
      bus.csr_valid = cv;
      bus.csr_addr  = 12'(addr);
      bus.csr_op    = 2'(op);
      bus.csr_wdata = wd;
      bus.fp_valid  = fv;
      bus.fp_flags  = 5'(ff);
      bus.instr_rm  = 3'(rm);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int unsigned r, addr;
      n_cmp = 0; n_bad = 0; m_valid = 0;
      m_frm = 0; m_ff = 0; m_dirty = 0;

      // reset with a retiring FP op that must not survive
      reset = 1'b1;
      drive(0, 0, 0, 0, 1, 5'h1F, 0);
      settle(); advance();
      settle(); advance();
      reset = 1'b0;
      idle();
      settle();
      check("rst_fflags", 32'(fflags_out), 0);
      check("rst_frm", 32'(frm_out), 0);
      check("rst_fs_dirty", 32'(fs_dirty), 0);
      advance();

      // accrual: compare-unit NV then NX
      drive(0, 0, 0, 0, 1, 5'h10, 0); settle(); advance();
      drive(0, 0, 0, 0, 1, 5'h01, 0); settle();
      check("acc_dirty1", 32'(fs_dirty), 1);
      advance();
      idle(); settle();
      check("acc_fflags", 32'(fflags_out), 5'h11);
      check("acc_dirty2", 32'(fs_dirty), 1);
      advance();
      settle();
      check("acc_dirty_end", 32'(fs_dirty), 0);
      advance();

      // same-cycle bypass through an RS read of fcsr
      drive(1, 12'h001, 1, 1, 0, 0, 0); settle(); advance();
      drive(1, 12'h003, 2, 0, 1, 5'h10, 0); settle();
      check("byp_rdata", bus.csr_rdata, 32'h11);
      advance();
      idle(); settle();
      check("byp_fflags", 32'(fflags_out), 5'h11);
      advance();

      // RC clear racing a new flag
      drive(1, 12'h001, 1, 5'h1F, 0, 0, 0); settle(); advance();
      drive(1, 12'h001, 3, 5'h1F, 1, 5'h04, 0); settle(); advance();
      idle(); settle();
      check("rc_fflags", 32'(fflags_out), 5'h04);
      advance();

      drive(1, 12'h003, 1, 32'hE5, 0, 0, 0); settle(); advance();
      idle(); settle();
      check("fcsr_frm", 32'(frm_out), 3'b111);
      check("fcsr_fflags", 32'(fflags_out), 5'h05);
      advance();

      // dynamic rounding mode
      drive(1, 12'h002, 1, 2, 0, 0, 7); settle(); advance();
      drive(0, 0, 0, 0, 0, 0, 7); settle();
      check("dyn_rm", 32'(bus.rm_out), 3'b010);
      check("dyn_legal", 32'(bus.rm_illegal), 0);
      advance();
      drive(1, 12'h002, 1, 5, 0, 0, 7); settle(); advance();
      drive(0, 0, 0, 0, 0, 0, 7); settle();
      check("dyn_rsvd", 32'(bus.rm_illegal), 1);
      advance();
      drive(0, 0, 0, 0, 0, 0, 6); settle();
      check("static_rsvd", 32'(bus.rm_illegal), 1);
      advance();
      drive(0, 0, 0, 0, 0, 0, 3); settle();
      check("static_rm", 32'(bus.rm_out), 3);
      advance();

      // non-hit address
      drive(1, 12'h300, 1, 32'hFF, 0, 0, 0); settle();
      check("nohit_hit", 32'(bus.csr_hit), 0);
      check("nohit_rdata", bus.csr_rdata, 0);
      advance();
      idle(); settle();
      check("nohit_frm", 32'(frm_out), 5);
      check("nohit_fflags", 32'(fflags_out), 5'h05);
      check("nohit_dirty", 32'(fs_dirty), 0);
      advance();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         addr = (r < 3) ? 1 : (r < 5) ? 2 : (r < 8) ? 3 : (r == 8) ? 12'h300 : $urandom_range(0, 4095);
         drive($urandom_range(0, 1), addr, $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? 0 : $urandom,
               $urandom_range(0, 2) != 0,
               ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 31),
               $urandom_range(0, 7));
         reset = ($urandom_range(0, 99) == 0);
         settle();
         advance();
      end
      reset = 1'b0;
      idle();
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fp_csr_flags.md
# fp_csr_flags

Floating-point control/status register block that sits directly downstream of the FP compare, arithmetic and convert units. Owns `fcsr` (`frm` + `fflags`) and accumulates the sticky exception flags each FP unit raises, including `flag_nv` from the compare unit. Serves Zicsr accesses to `fflags` (0x001), `frm` (0x002) and `fcsr` (0x003). Resolves the dynamic rounding mode for the FP units and flags reserved encodings as illegal.

## Interface
- `XLEN`, default 32. Width of the CSR data path; upper bits read as zero.
- `clk`  in  1  Core clock. One clock domain.
- `reset`  in  1  Synchronous, active-high reset.
- `csr_valid`  in  1  CSR instruction commits this cycle.
- `csr_addr`  in  12  CSR address.
- `csr_op`  in  2  Operation: 01 RW, 10 RS (set), 11 RC (clear), 00 no-op.
- `csr_wdata`  in  XLEN  rs1 value or zero-extended immediate.
- `csr_rdata`  out  XLEN  Combinational read value; see bypass rule.
- `csr_hit`  out  1  `csr_addr` is 0x001, 0x002 or 0x003.
- `fp_valid`  in  1  An FP instruction retires this cycle.
- `fp_flags`  in  5  Flags of that instruction, ordered {NV,DZ,OF,UF,NX}. The compare unit's `flag_nv` drives bit 4.
- `instr_rm`  in  3  rm field of the decoding FP instruction.
- `rm_out`  out  3  Effective rounding mode: `frm` if `instr_rm` is 111, else `instr_rm`.
- `rm_illegal`  out  1  Effective rm is 101, 110 or 111.
- `frm_out`  out  3  Current `frm` register value.
- `fflags_out`  out  5  Current `fflags` register value.
- `fs_dirty`  out  1  One-cycle pulse for mstatus.FS = Dirty.

## Operation
- **State.** `frm[2:0]` and `fflags[4:0]`.
  - Reset: both 0. `fs_dirty` is 0 during and after reset until an event sets it.
- **Read data (XLEN wide, zero-extended).**
  - `fflags` address returns {0, F}.
  - `frm` address returns {0, frm}.
  - `fcsr` address returns {0, frm, F}.
  - F = `fflags | (fp_valid ? fp_flags : 0)`. This is a same-cycle bypass of the retiring FP instruction.
  - Any other address returns 0, and `csr_hit` is 0.
- **CSR write value.** W = `csr_wdata` for RW, old|`csr_wdata` for RS, old&~`csr_wdata` for RC.
  - "old" is the bypassed read value.
  - Only the field bits are written: 5 bits for `fflags`, 3 for `frm`, 8 (frm=W[7:5], fflags=W[4:0]) for `fcsr`.
  - RS/RC with `csr_wdata`==0 still counts as a write.
- **Accrual.** When `fp_valid` is high, `fflags_next |= fp_flags`.
- **Simultaneous CSR write and `fp_valid` to `fflags` or `fcsr`.**
  - next `fflags` = CSR-written value | `fp_flags`.
  - Exception: an RW/RC write that clears a bit wins over the bypassed-in copy of the same bit, but the `fp_flags` bit is then ORed in again. Net rule: next = W_field | `fp_flags`.
- **`frm` writes.** Any value 0–7 is stored. Reserved values are reported only via `rm_illegal` when used dynamically.
- **`rm_out` / `rm_illegal`.** Combinational from `instr_rm` and registered `frm`.
  - Not bypassed from a same-cycle CSR write; the pipeline serializes `frm` writes.
- **`fs_dirty`.** Registered. Pulses 1 the cycle after either event:
  - `fp_valid` with `fp_flags`≠0, or
  - `csr_valid && csr_hit && csr_op≠00`.
- `csr_valid` with `csr_op`=00, or with a non-hit address, changes no state.

## Timing
- Register update is on the `clk` rising edge. New values are visible on `fflags_out`/`frm_out` one cycle after the commit cycle.
- `csr_rdata`, `csr_hit`, `rm_out` and `rm_illegal` are zero-latency combinational.
- `reset` overrides every input in the same cycle: state goes to 0 and `fs_dirty` to 0. No accrual or write survives a reset cycle.
- Back-to-back FP retirements accrue every cycle with no bubbles.
- A CSR read in cycle N+1 observes all flags accrued through cycle N.

## Test plan
- **Reset.** Hold `reset` 2 cycles with `fp_valid`=1, `fp_flags`=5'h1F -> `fflags_out`=0, `frm_out`=0, `fs_dirty`=0 after release.
- **Accrual from the compare unit.** FLT with qNaN gives `fp_flags`=5'h10, then an add gives 5'h01 -> `fflags_out`=5'h11. `fs_dirty` pulses twice.
- **Same-cycle bypass.** `fflags`=5'h01; read `fcsr` (op RS, `wdata`=0) with `fp_valid`, `fp_flags`=5'h10 -> `csr_rdata`=32'h11, next `fflags`=5'h11.
- **Simultaneous write.**
  - `fflags`=5'h1F; CSRRC `fflags`, `wdata`=5'h1F, while `fp_flags`=5'h04 -> next `fflags`=5'h04.
  - CSRRW `fcsr` 32'hE5 -> `frm`=3'b111, `fflags`=5'h05.
- **Dynamic rm.**
  - `frm`=3'b010, `instr_rm`=111 -> `rm_out`=010, `rm_illegal`=0.
  - `frm`=3'b101 -> `rm_illegal`=1.
  - `instr_rm`=110 -> `rm_illegal`=1 regardless of `frm`.
- **Non-hit.** CSRRW to 0x300 with `wdata`=32'hFF -> `csr_hit`=0, `csr_rdata`=0, no state change, no `fs_dirty`.
